multi_mode_mult_seq: RTL and testbench

Sequential, handshaked successor to the single-cycle multi-mode multiplier. It computes square, low-half, high-half or full products of NUM_ELEMENTS-word redundant operands, one row of partial products per cycle, into a self-normalising shift accumulator. It emits fully carry-propagated WORD_LEN-bit digits plus an overflow residue. It sits in the modular-squaring datapath where area must be traded for latency, and LO mode terminates early.

---
 rtl/multi_mode_mult_pkg.sv | 24 ++
 rtl/multi_mode_mult_seq_if.sv | 34 +++
 rtl/acc_shift_row.sv | 60 ++++++
 rtl/async_mult.sv | 13 +
 rtl/multi_mode_mult_seq.sv | 130 +++++++++++++
 tb/tb_multi_mode_mult_seq.sv | 233 +++++++++++++++++++++++
 6 files changed

// File: rtl/multi_mode_mult_pkg.sv
// Shared types for the sequential multi-mode multiplier: operating modes,
// FSM states and the derived accumulator element width.
package multi_mode_mult_pkg;

   typedef enum logic [1:0] {
      SQR      = 2'd0,
      MUL_LO   = 2'd1,
      MUL_HI   = 2'd2,
      MUL_FULL = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MUL   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_e;

   // Wide enough for one word, a full product high half and the inter-element carry.
   function automatic int acc_bit_len(input int dsp_bit_len, input int word_len);
      return 2 * dsp_bit_len - word_len + 2;
   endfunction

endpackage

// File: rtl/multi_mode_mult_seq_if.sv
// Request/response bus of the sequential multiplier: valid/ready request with
// operands, valid/ready response with normalised digits and overflow residue.
interface multi_mode_mult_seq_if
   import multi_mode_mult_pkg::*;
#(
   parameter int NUM_ELEMENTS = 33,
   parameter int DSP_BIT_LEN  = 17,
   parameter int WORD_LEN     = 16
) ();

   localparam int ACC_BIT_LEN = acc_bit_len(DSP_BIT_LEN, WORD_LEN);

   logic                                       i_val;
   logic                                       o_rdy;
   mode_e                                      i_mode;
   logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0]   i_dat_a;
   logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0]   i_dat_b;
   logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0]   i_add_term;
   logic                                       o_val;
   logic                                       i_rdy;
   logic [2*NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0] o_dat;
   logic [ACC_BIT_LEN-1:0]                     o_ovf;

   modport master (
      output i_val, i_mode, i_dat_a, i_dat_b, i_add_term, i_rdy,
      input  o_rdy, o_val, o_dat, o_ovf
   );

   modport slave (
      input  i_val, i_mode, i_dat_a, i_dat_b, i_add_term, i_rdy,
      output o_rdy, o_val, o_dat, o_ovf
   );

endinterface

// File: rtl/acc_shift_row.sv
// One row of partial products a[j]*b plus the self-normalising accumulator
// update that retires the lowest digit and shifts the rest down by a word.
module acc_shift_row #(
   parameter int NUM_ELEMENTS = 33,
   parameter int DSP_BIT_LEN  = 17,
   parameter int WORD_LEN     = 16,
   parameter int ACC_BIT_LEN  = 20
) (
   input  logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0] a_i,
   input  logic [DSP_BIT_LEN-1:0]                   b_i,
   input  logic                                     mul_en_i,
   input  logic [NUM_ELEMENTS:0][ACC_BIT_LEN-1:0]   acc_i,
   output logic [NUM_ELEMENTS:0][ACC_BIT_LEN-1:0]   acc_o,
   output logic [WORD_LEN-1:0]                      digit_o
);

   localparam int PROD_W = 2 * DSP_BIT_LEN;

   logic [DSP_BIT_LEN-1:0] b_eff;
   logic [PROD_W-1:0]      prod  [NUM_ELEMENTS];
   logic [ACC_BIT_LEN-1:0] p_lo  [NUM_ELEMENTS+1];
   logic [ACC_BIT_LEN-1:0] p_hi  [NUM_ELEMENTS+1];
   logic [ACC_BIT_LEN-1:0] sum   [NUM_ELEMENTS+1];

   // Flush rows reuse the same datapath with a zero multiplier.
   assign b_eff = mul_en_i ? b_i : '0;

   for (genvar j = 0; j < NUM_ELEMENTS; j++) begin : g_mult
      async_mult #(.A_W(DSP_BIT_LEN), .B_W(DSP_BIT_LEN)) u_mult (
         .a_i (a_i[j]),
         .b_i (b_eff),
         .p_o (prod[j])
      );
   end

   // sum[j] is the full column at weight j; its low word moves down one slot
   // and its high bits stay as carry, so elements never grow with N.
   for (genvar j = 0; j <= NUM_ELEMENTS; j++) begin : g_elem
      if (j < NUM_ELEMENTS) begin : g_lo
         assign p_lo[j] = ACC_BIT_LEN'(prod[j][WORD_LEN-1:0]);
      end else begin : g_lo_top
         assign p_lo[j] = '0;
      end
      if (j > 0) begin : g_hi
         assign p_hi[j] = ACC_BIT_LEN'(prod[j-1][PROD_W-1:WORD_LEN]);
      end else begin : g_hi_bot
         assign p_hi[j] = '0;
      end
      assign sum[j] = acc_i[j] + p_lo[j] + p_hi[j];
      if (j < NUM_ELEMENTS) begin : g_upd
         assign acc_o[j] = ACC_BIT_LEN'(sum[j+1][WORD_LEN-1:0])
                         + ACC_BIT_LEN'(sum[j][ACC_BIT_LEN-1:WORD_LEN]);
      end else begin : g_upd_top
         assign acc_o[j] = ACC_BIT_LEN'(sum[j][ACC_BIT_LEN-1:WORD_LEN]);
      end
   end

   assign digit_o = sum[0][WORD_LEN-1:0];

endmodule

// File: rtl/async_mult.sv
// Combinational unsigned multiplier used as the per-element DSP product.
module async_mult #(
   parameter int A_W = 17,
   parameter int B_W = 17
) (
   input  logic [A_W-1:0]     a_i,
   input  logic [B_W-1:0]     b_i,
   output logic [A_W+B_W-1:0] p_o
);

   assign p_o = (A_W + B_W)'(a_i) * (A_W + B_W)'(b_i);

endmodule

// File: rtl/multi_mode_mult_seq.sv
// Sequential multi-mode multiplier: one partial-product row per cycle, then a
// flush phase that drains the accumulator into the upper result digits.
module multi_mode_mult_seq
   import multi_mode_mult_pkg::*;
#(
   parameter int NUM_ELEMENTS = 33,
   parameter int DSP_BIT_LEN  = 17,
   parameter int WORD_LEN     = 16
) (
   input logic                  i_clk,
   input logic                  i_rst_n,
   multi_mode_mult_seq_if.slave bus
);

   localparam int ACC_BIT_LEN = acc_bit_len(DSP_BIT_LEN, WORD_LEN);
   localparam int CNT_W       = $clog2(NUM_ELEMENTS);
   localparam int IDX_W       = $clog2(2 * NUM_ELEMENTS);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_ELEMENTS - 1);

   typedef logic [NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0]   opnd_t;
   typedef logic [NUM_ELEMENTS:0][ACC_BIT_LEN-1:0]     acc_t;
   typedef logic [2*NUM_ELEMENTS-1:0][DSP_BIT_LEN-1:0] dat_t;

   state_e                 state_q, state_d;
   mode_e                  mode_q, mode_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   opnd_t                  a_q, a_d, b_q, b_d;
   acc_t                   acc_q, acc_d, row_acc;
   dat_t                   dat_q, dat_d;
   logic [ACC_BIT_LEN-1:0] ovf_q, ovf_d;
   logic [WORD_LEN-1:0]    row_digit;
   logic [IDX_W-1:0]       flush_idx;

   assign flush_idx = IDX_W'(NUM_ELEMENTS) + IDX_W'(cnt_q);

   acc_shift_row #(
      .NUM_ELEMENTS (NUM_ELEMENTS),
      .DSP_BIT_LEN  (DSP_BIT_LEN),
      .WORD_LEN     (WORD_LEN),
      .ACC_BIT_LEN  (ACC_BIT_LEN)
   ) u_row (
      .a_i      (a_q),
      .b_i      (b_q[cnt_q]),
      .mul_en_i (state_q == MUL),
      .acc_i    (acc_q),
      .acc_o    (row_acc),
      .digit_o  (row_digit)
   );

   always_comb begin
      // NOTE: every next-state variable gets its default first so no latch is inferred.
      state_d = state_q;
      mode_d  = mode_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      dat_d   = dat_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (bus.i_val) begin
               state_d = MUL;
               mode_d  = bus.i_mode;
               cnt_d   = '0;
               a_d     = bus.i_dat_a;
               b_d     = (bus.i_mode == SQR) ? bus.i_dat_a : bus.i_dat_b;
               acc_d   = '0;
               for (int j = 0; j < NUM_ELEMENTS; j++) begin
                  acc_d[j] = ACC_BIT_LEN'(bus.i_add_term[j]);
               end
               dat_d   = '0;
               ovf_d   = '0;
            end
         end
         MUL: begin
            acc_d = row_acc;
            if (mode_q != MUL_HI) dat_d[cnt_q] = DSP_BIT_LEN'(row_digit);
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               state_d = (mode_q == MUL_LO) ? DONE : FLUSH;
            end
         end
         FLUSH: begin
            acc_d            = row_acc;
            dat_d[flush_idx] = DSP_BIT_LEN'(row_digit);
            cnt_d            = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               ovf_d   = row_acc[0];
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.i_rdy) state_d = IDLE;
         end
      endcase
   end

   // NOTE: non-blocking only; accumulator and output buffer are reset too, so an
   // aborted operation leaves no stale digits behind.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         mode_q  <= SQR;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         dat_q   <= '0;
         ovf_q   <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         dat_q   <= dat_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.o_rdy = (state_q == IDLE);
   assign bus.o_val = (state_q == DONE);
   assign bus.o_dat = dat_q;
   assign bus.o_ovf = ovf_q;

endmodule

// File: tb/tb_multi_mode_mult_seq.sv
// Self-checking bench for multi_mode_mult_seq with N=4: a vector table plus
// hand-written reset, backpressure and mid-flush abort sequences.
module tb_multi_mode_mult_seq;
   import multi_mode_mult_pkg::*;

   localparam int N   = 4;
   localparam int D   = 17;
   localparam int W   = 16;
   localparam int ACC = 20;
   localparam int NV  = 9;

   typedef logic [N-1:0][D-1:0]   opnd_t;
   typedef logic [2*N-1:0][D-1:0] dat_t;
   typedef logic [ACC-1:0]        ovf_t;

   typedef struct {
      mode_e mode;
      opnd_t a;
      opnd_t b;
      opnd_t add;
      dat_t  dat;
      ovf_t  ovf;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;
   vec_t vecs [NV];

   multi_mode_mult_seq_if #(.NUM_ELEMENTS(N), .DSP_BIT_LEN(D), .WORD_LEN(W)) bus ();

   multi_mode_mult_seq #(.NUM_ELEMENTS(N), .DSP_BIT_LEN(D), .WORD_LEN(W)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   function automatic opnd_t rand_opnd();
      opnd_t o;
      for (int i = 0; i < N; i++) o[i] = D'($urandom_range(0, 32'h1FFFF));
      return o;
   endfunction

   // Wide-integer reference: value = a*b + add, then per-mode digit masking.
   task automatic model(input mode_e m, input opnd_t a, input opnd_t b, input opnd_t add,
                        output dat_t dat, output ovf_t ovf);
      logic [191:0] av, bv, cv, r;
      av = '0; bv = '0; cv = '0;
      for (int i = 0; i < N; i++) begin
         av = av + (192'(a[i]) << (W * i));
         bv = bv + (192'(b[i]) << (W * i));
         cv = cv + (192'(add[i]) << (W * i));
      end
      if (m == SQR) bv = av;
      r = av * bv + cv;
      for (int d = 0; d < 2 * N; d++) begin
         dat[d] = {1'b0, r[W*d +: W]};
         if ((m == MUL_LO && d >= N) || (m == MUL_HI && d < N)) dat[d] = '0;
      end
      ovf = (m == MUL_LO) ? '0 : ovf_t'(r >> (2 * N * W));
   endtask

   // Issues one request, returns the result and the accept-to-o_val edge count.
   task automatic run_req(input mode_e m, input opnd_t a, input opnd_t b, input opnd_t add,
                          output dat_t dat, output ovf_t ovf, output int lat);
      int guard;
      guard = 0;
      while (!bus.o_rdy && guard < 50) begin
         tick();
         guard++;
      end
      check("rdy_before_req", 256'(bus.o_rdy), 256'(1));
      bus.i_mode     = m;
      bus.i_dat_a    = a;
      bus.i_dat_b    = b;
      bus.i_add_term = add;
      bus.i_val      = 1'b1;
      tick();
      bus.i_val      = 1'b0;
      bus.i_dat_a    = '1;
      bus.i_dat_b    = '1;
      bus.i_add_term = '1;
      check("rdy_low_after_accept", 256'(bus.o_rdy), 256'(0));
      lat = 0;
      while (!bus.o_val && lat < 100) begin
         tick();
         lat++;
      end
      dat = bus.o_dat;
      ovf = bus.o_ovf;
   endtask

   task automatic handshake();
      bus.i_rdy = 1'b1;
      tick();
      bus.i_rdy = 1'b0;
      check("val_drop_after_hs", 256'(bus.o_val), 256'(0));
      check("rdy_after_hs", 256'(bus.o_rdy), 256'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      dat_t got_dat;
      ovf_t got_ovf;
      int   lat;
      int   exp_lat;
      bit   saw_val;

      bus.i_val = 1'b0; bus.i_rdy = 1'b0; bus.i_mode = SQR;
      bus.i_dat_a = '0; bus.i_dat_b = '0; bus.i_add_term = '0;

      // Digit lists below are written most-significant element first.
      vecs[0] = '{MUL_FULL, {4{17'hFFFF}}, {4{17'hFFFF}}, '0,
                  {17'hFFFF, 17'hFFFF, 17'hFFFF, 17'hFFFE, 17'h0, 17'h0, 17'h0, 17'h1}, '0};
      vecs[1] = '{MUL_LO, {17'h0, 17'h0, 17'h0, 17'h3}, {17'h0, 17'h0, 17'h0, 17'h5},
                  {17'h0, 17'h0, 17'h0, 17'hFFFF},
                  {17'h0, 17'h0, 17'h0, 17'h0, 17'h0, 17'h0, 17'h1, 17'hE}, '0};
      vecs[2] = '{SQR, {17'h0, 17'h0, 17'h0, 17'h10000}, rand_opnd(), '0,
                  {17'h0, 17'h0, 17'h0, 17'h0, 17'h0, 17'h1, 17'h0, 17'h0}, '0};
      vecs[3] = '{MUL_HI, {17'h1, 17'h0, 17'h0, 17'h0}, {17'h1, 17'h0, 17'h0, 17'h0},
                  {17'h0, 17'h0, 17'h0, 17'hFFFF},
                  {17'h0, 17'h1, 17'h0, 17'h0, 17'h0, 17'h0, 17'h0, 17'h0}, '0};
      vecs[4] = '{MUL_FULL, {17'h10000, 17'h0, 17'h0, 17'h0}, {17'h10000, 17'h0, 17'h0, 17'h0},
                  '0, '0, 20'h1};
      vecs[5] = '{MUL_LO, {17'h0, 17'h0, 17'h0, 17'h1FFFF}, {17'h0, 17'h0, 17'h0, 17'h1FFFF}, '0,
                  {17'h0, 17'h0, 17'h0, 17'h0, 17'h0, 17'h3, 17'hFFFC, 17'h1}, '0};
      vecs[6] = '{MUL_HI, {4{17'h1FFFF}}, {4{17'h1FFFF}}, '0, '0, '0};
      vecs[7] = '{MUL_FULL, rand_opnd(), rand_opnd(), rand_opnd(), '0, '0};
      vecs[8] = '{SQR, rand_opnd(), rand_opnd(), rand_opnd(), '0, '0};
      for (int i = 6; i < NV; i++)
         model(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].add, vecs[i].dat, vecs[i].ovf);

      // Reset, then assert reset again while idle.
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      check("reset_rdy", 256'(bus.o_rdy), 256'(1));
      check("reset_val", 256'(bus.o_val), 256'(0));
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      check("idle_rst_val", 256'(bus.o_val), 256'(0));
      check("idle_rst_dat", 256'(bus.o_dat), 256'(0));
      check("idle_rst_ovf", 256'(bus.o_ovf), 256'(0));
      tick();
      rst_n = 1'b1;
      tick();
      check("idle_rst_rdy_after", 256'(bus.o_rdy), 256'(1));

      // Vector table.
      for (int i = 0; i < NV; i++) begin
         run_req(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].add, got_dat, got_ovf, lat);
         exp_lat = (vecs[i].mode == MUL_LO) ? N : 2 * N;
         check($sformatf("vec%0d_lat", i), 256'(lat), 256'(exp_lat));
         check($sformatf("vec%0d_dat", i), 256'(got_dat), 256'(vecs[i].dat));
         check($sformatf("vec%0d_ovf", i), 256'(got_ovf), 256'(vecs[i].ovf));
         if (i == 6) check("hi_ovf_nonzero", 256'(got_ovf != '0), 256'(1));
         handshake();
      end

      // Backpressure: result held while i_rdy=0, i_val pulses ignored.
      run_req(vecs[0].mode, vecs[0].a, vecs[0].b, vecs[0].add, got_dat, got_ovf, lat);
      check("bp_lat", 256'(lat), 256'(2 * N));
      for (int c = 0; c < 5; c++) begin
         bus.i_val   = (c % 2 == 0);
         bus.i_mode  = MUL_LO;
         bus.i_dat_a = rand_opnd();
         tick();
         check($sformatf("bp%0d_val", c), 256'(bus.o_val), 256'(1));
         check($sformatf("bp%0d_rdy", c), 256'(bus.o_rdy), 256'(0));
         check($sformatf("bp%0d_dat", c), 256'(bus.o_dat), 256'(vecs[0].dat));
         check($sformatf("bp%0d_ovf", c), 256'(bus.o_ovf), 256'(vecs[0].ovf));
      end
      bus.i_val = 1'b0;
      handshake();
      run_req(vecs[1].mode, vecs[1].a, vecs[1].b, vecs[1].add, got_dat, got_ovf, lat);
      check("post_bp_lat", 256'(lat), 256'(N));
      check("post_bp_dat", 256'(got_dat), 256'(vecs[1].dat));
      handshake();

      // Reset in the middle of FLUSH.
      bus.i_mode = MUL_FULL; bus.i_dat_a = {4{17'hFFFF}}; bus.i_dat_b = {4{17'hFFFF}};
      bus.i_add_term = '0; bus.i_val = 1'b1;
      tick();
      bus.i_val = 1'b0;
      repeat (N + 2) tick();
      check("pre_abort_partial", 256'(bus.o_dat[0]), 256'(1));
      rst_n = 1'b0;
      #1;
      check("abort_val", 256'(bus.o_val), 256'(0));
      check("abort_dat", 256'(bus.o_dat), 256'(0));
      check("abort_ovf", 256'(bus.o_ovf), 256'(0));
      tick();
      rst_n = 1'b1;
      saw_val = 1'b0;
      for (int c = 0; c < 3 * N; c++) begin
         tick();
         if (bus.o_val) saw_val = 1'b1;
      end
      check("abort_no_spurious_val", 256'(saw_val), 256'(0));
      run_req(MUL_FULL, {17'h0, 17'h0, 17'h0, 17'h1}, {17'h0, 17'h0, 17'h0, 17'h1}, '0,
              got_dat, got_ovf, lat);
      check("after_abort_lat", 256'(lat), 256'(2 * N));
      check("after_abort_dat", 256'(got_dat), 256'(1));
      check("after_abort_ovf", 256'(got_ovf), 256'(0));
      handshake();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
